// File: rtl/sram_access_ctrl_if.sv
// Request/response bundle between the group scan logic and the SRAM access controller.
// master drives requests, slave answers with ready/err/rdata.
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              sram_ren;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;
  logic              sram_err;

  modport master (
    output sram_ren,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata,
    input  sram_ready,
    input  sram_err
  );

  modport slave (
    input  sram_ren,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata,
    output sram_ready,
    output sram_err
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Turns a level-held read/write request into one single-cycle SRAM macro access.
// All outputs are registered from the next-state values.
module sram_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_access_ctrl_if.slave bus,
  output logic              busy,
  output logic              mem_cen_n,
  output logic              mem_wen_n,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("sram_access_ctrl: RD_LAT must be in 1..4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE,
    S_RELEASE
  } state_e;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_e            state;
  state_e            state_nx;
  logic [1:0]        cnt;
  logic              op_wr;

  logic              req;
  logic              illegal;
  logic              rd_last;

  logic              cen_nx;
  logic              wen_nx;
  logic [ADDR_W-1:0] a_nx;
  logic [DATA_W-1:0] d_nx;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_nx;
  logic              ready_q;
  logic              ready_nx;
  logic              err_q;
  logic              err_nx;
  logic              busy_nx;

  assign req     = bus.sram_ren | bus.sram_wen;
  assign illegal = bus.sram_ren & bus.sram_wen;
  assign rd_last = (state == S_WAIT) && (cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
      op_wr <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req)
        op_wr <= bus.sram_wen & ~bus.sram_ren;
      if (state == S_ACCESS)
        cnt <= LAT_LOAD;
      else if (state == S_WAIT)
        cnt <= cnt - 2'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req)
          state_nx = illegal ? S_DONE : S_ACCESS;
      end
      S_ACCESS:  state_nx = op_wr ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (cnt == 2'd0)
          state_nx = S_DONE;
      end
      S_DONE:    state_nx = S_RELEASE;
      S_RELEASE: begin
        if (!req)
          state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  // ACCESS is only entered from IDLE, so the live request is the captured op
  always_comb begin
    cen_nx   = 1'b1;
    wen_nx   = 1'b1;
    a_nx     = mem_a;
    d_nx     = mem_d;
    rdata_nx = rdata_q;
    ready_nx = 1'b0;
    err_nx   = 1'b0;
    busy_nx  = (state_nx != S_IDLE);
    if (state_nx == S_ACCESS) begin
      cen_nx = 1'b0;
      wen_nx = ~bus.sram_wen;
      a_nx   = bus.sram_addr;
      d_nx   = bus.sram_wdata;
    end
    if (rd_last)
      rdata_nx = mem_q;
    if (state_nx == S_DONE) begin
      ready_nx = 1'b1;
      err_nx   = (state == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cen_n <= 1'b1;
      mem_wen_n <= 1'b1;
      mem_a     <= '0;
      mem_d     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_cen_n <= cen_nx;
      mem_wen_n <= wen_nx;
      mem_a     <= a_nx;
      mem_d     <= d_nx;
      rdata_q   <= rdata_nx;
      ready_q   <= ready_nx;
      err_q     <= err_nx;
      busy      <= busy_nx;
    end
  end

  assign bus.sram_rdata = rdata_q;
  assign bus.sram_ready = ready_q;
  assign bus.sram_err   = err_q;

endmodule
